// File: rtl/types_pkg.sv
// Shared instruction-memory types.
// Address/word types plus arbiter port and in-flight bundles.
package types_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 32;
  localparam int MEM_SIZE    = 1 << IMEM_ADDR_W;

  typedef logic [IMEM_ADDR_W-1:0] address_t;
  typedef logic [IMEM_DATA_W-1:0] word_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     valid;
    port_id_e owner;
    logic     drop;
  } inflight_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO with flush.
// One instance buffers read data for each arbiter port.
module imem_rsp_fifo
  import types_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic [1:0]        o_count,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem0;
  logic [DATA_W-1:0] r_mem1;
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_flush) begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr) r_mem1 <= i_din;
        else      r_mem0 <= i_din;
        r_wr <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_dout  = r_rd ? r_mem1 : r_mem0;
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/imem_port_arbiter.sv
// Fetch/loader arbiter for the shared single-port imem.
// Tracks the one-cycle read latency and buffers data per port.
module imem_port_arbiter
  import types_pkg::*;
#(
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_req_we,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [DATA_W-1:0] l_req_wdata,
  output logic              l_rsp_valid,
  input  logic              l_rsp_ready,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  inflight_t         r_inf;
  inflight_t         w_inf_nxt;
  logic [WW-1:0]     r_wait;
  logic [ADDR_W-1:0] r_addr;

  logic [1:0] w_f_cnt, w_l_cnt;
  logic [1:0] w_f_occ, w_l_occ;
  logic       w_f_empty, w_l_empty;
  logic       w_f_inf, w_l_inf;
  logic       w_f_pop, w_l_pop;
  logic       w_f_push, w_l_push;
  logic       w_f_elig, w_l_elig;
  logic       w_f_want, w_l_want;
  logic       w_gnt_f, w_gnt_l;
  logic       w_f_drop;

  assign w_f_inf = r_inf.valid & (r_inf.owner == PORT_F);
  assign w_l_inf = r_inf.valid & (r_inf.owner == PORT_L);
  assign w_f_occ = w_f_cnt + {1'b0, w_f_inf};
  assign w_l_occ = w_l_cnt + {1'b0, w_l_inf};

  assign w_f_pop = f_rsp_valid & f_rsp_ready;
  assign w_l_pop = l_rsp_valid & l_rsp_ready;

  // A full port may still issue when a pop frees a slot this cycle.
  assign w_f_elig = (w_f_occ < 2'd2) |
                    ((w_f_occ == 2'd2) & w_f_pop);
  assign w_l_elig = l_req_we | (w_l_occ < 2'd2) |
                    ((w_l_occ == 2'd2) & w_l_pop);

  assign w_f_want = rst_n & f_req_valid & w_f_elig & ~f_flush;
  assign w_l_want = rst_n & l_req_valid & w_l_elig;

  assign w_gnt_l = w_l_want &
                   (~w_f_want | (r_wait == WW'(MAX_WAIT)));
  assign w_gnt_f = w_f_want & ~w_gnt_l;

  assign f_req_ready = w_gnt_f;
  assign l_req_ready = w_gnt_l;
  assign mem_en      = w_gnt_f | w_gnt_l;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = r_addr;
    mem_wdata = '0;
    unique case (1'b1)
      w_gnt_l: begin
        mem_we    = l_req_we;
        mem_addr  = l_req_addr;
        mem_wdata = l_req_wdata;
      end
      w_gnt_f: begin
        mem_addr  = f_req_addr;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_inf_nxt       = '0;
    w_inf_nxt.valid = w_gnt_f | (w_gnt_l & ~l_req_we);
    w_inf_nxt.owner = w_gnt_l ? PORT_L : PORT_F;
    w_inf_nxt.drop  = 1'b0;
  end

  // A flush kills the fetch read whose data lands this cycle.
  assign w_f_drop = r_inf.drop | f_flush;
  assign w_f_push = w_f_inf & ~w_f_drop;
  assign w_l_push = w_l_inf & ~r_inf.drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inf  <= '0;
      r_wait <= '0;
      r_addr <= '0;
    end else begin
      r_inf <= w_inf_nxt;
      if (mem_en) r_addr <= mem_addr;
      if (!l_req_valid || w_gnt_l)
        r_wait <= '0;
      else if (r_wait != WW'(MAX_WAIT))
        r_wait <= r_wait + WW'(1);
    end
  end

  imem_rsp_fifo #(.DATA_W(DATA_W)) u_f_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_f_push),
    .i_pop   (w_f_pop),
    .i_flush (f_flush),
    .i_din   (mem_rdata),
    .o_dout  (f_rsp_data),
    .o_count (w_f_cnt),
    .o_empty (w_f_empty)
  );

  imem_rsp_fifo #(.DATA_W(DATA_W)) u_l_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_l_push),
    .i_pop   (w_l_pop),
    .i_flush (1'b0),
    .i_din   (mem_rdata),
    .o_dout  (l_rsp_data),
    .o_count (w_l_cnt),
    .o_empty (w_l_empty)
  );

  assign f_rsp_valid = ~w_f_empty;
  assign l_rsp_valid = ~w_l_empty;
  assign busy        = r_inf.valid | ~w_f_empty | ~w_l_empty;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus random
// traffic, scoreboarded against a queue-based port model.
module tb_imem_port_arbiter;
  import types_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req_valid, f_req_ready, f_flush;
  logic [AW-1:0] f_req_addr;
  logic          f_rsp_valid, f_rsp_ready;
  logic [DW-1:0] f_rsp_data;
  logic          l_req_valid, l_req_ready, l_req_we;
  logic [AW-1:0] l_req_addr;
  logic [DW-1:0] l_req_wdata;
  logic          l_rsp_valid, l_rsp_ready;
  logic [DW-1:0] l_rsp_data;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem    [MEM_SIZE];
  logic [DW-1:0] refmem [MEM_SIZE];
  logic [DW-1:0] fq [$];
  logic [DW-1:0] lq [$];

  logic tb_init  = 1'b1;
  logic tb_final = 1'b0;
  logic tb_done  = 1'b0;
  logic f_hs = 1'b0;
  logic l_hs = 1'b0;
  int   wcnt   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready),
    .f_req_addr(f_req_addr), .f_flush(f_flush),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
    .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready),
    .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready),
    .l_rsp_data(l_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Synchronous-read memory array
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= refmem[i];
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor + reference model: one cycle of port behaviour per negedge
  always @(negedge clk) begin
    bit fp, lp, fe, le, fw, lw, ef, el;
    int fo, lo;
    if (tb_init)
      for (int i = 0; i < MEM_SIZE; i++) refmem[i] = $urandom;
    if (!rst_n) begin
      chk("reset_outs",
          {f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid,
           mem_en, mem_we, busy, f_rsp_data, mem_addr}, '0);
      chk("reset_data", {l_rsp_data, mem_wdata}, '0);
      fq.delete();
      lq.delete();
      wcnt = 0;
      f_hs = 1'b0;
      l_hs = 1'b0;
    end else if (tb_final && !tb_done) begin
      chk("drain_busy", busy, 0);
      chk("drain_fq", fq.size(), 0);
      chk("drain_lq", lq.size(), 0);
      tb_done = 1'b1;
    end else begin
      fo = fq.size();
      lo = lq.size();
      fp = f_rsp_valid & f_rsp_ready;
      lp = l_rsp_valid & l_rsp_ready;
      fe = (fo < 2) || (fo == 2 && fp);
      le = l_req_we || (lo < 2) || (lo == 2 && lp);
      fw = f_req_valid && fe && !f_flush;
      lw = l_req_valid && le;
      el = lw && (!fw || wcnt == MW);
      ef = fw && !el;
      chk("f_req_ready", f_req_ready, ef);
      chk("l_req_ready", l_req_ready, el);
      chk("mem_en", mem_en, ef | el);
      chk("busy", busy, (fo > 0) || (lo > 0));
      if (el)
        chk("mem_l", {mem_we, mem_addr, mem_wdata},
            {l_req_we, l_req_addr, l_req_wdata});
      else if (ef)
        chk("mem_f", {mem_we, mem_addr}, {1'b0, f_req_addr});
      else
        chk("mem_idle_we", mem_we, 0);
      if (fp) begin
        if (fq.size() == 0) chk("f_rsp_spurious", f_rsp_valid, 0);
        else chk("f_rsp_data", f_rsp_data, fq.pop_front());
      end
      if (lp) begin
        if (lq.size() == 0) chk("l_rsp_spurious", l_rsp_valid, 0);
        else chk("l_rsp_data", l_rsp_data, lq.pop_front());
      end
      if (f_flush) fq.delete();
      if (f_req_valid && f_req_ready)
        fq.push_back(refmem[f_req_addr]);
      if (l_req_valid && l_req_ready) begin
        if (l_req_we) refmem[l_req_addr] = l_req_wdata;
        else          lq.push_back(refmem[l_req_addr]);
      end
      if (!l_req_valid || l_req_ready) wcnt = 0;
      else if (wcnt < MW) wcnt++;
      f_hs = f_req_valid && f_req_ready;
      l_hs = l_req_valid && l_req_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_send(input logic [AW-1:0] a);
    f_req_addr  = a;
    f_req_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      step();
      if (f_hs) return;
    end
    $display("FAIL f_req_timeout addr %h", a);
    $fatal(1, "fetch request never accepted");
  endtask

  task automatic l_send(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    l_req_we    = we;
    l_req_addr  = a;
    l_req_wdata = d;
    l_req_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      step();
      if (l_hs) begin
        l_req_valid = 1'b0;
        return;
      end
    end
    $display("FAIL l_req_timeout addr %h", a);
    $fatal(1, "loader request never accepted");
  endtask

  task automatic idle(input int n);
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    f_rsp_ready = 1'b1;
    l_rsp_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    f_req_valid = 0; f_req_addr = '0; f_flush = 0; f_rsp_ready = 0;
    l_req_valid = 0; l_req_we = 0; l_req_addr = '0;
    l_req_wdata = '0; l_rsp_ready = 0;
    repeat (4) step();
    tb_init = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Reset in the middle of a fetch burst
    f_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) f_send(AW'(i + 8));
    rst_n = 1'b0;
    f_req_addr = '0;
    step();
    step();
    rst_n = 1'b1;
    f_send('0);
    idle(4);

    // Streaming
    for (int i = 0; i < 16; i++) f_send(AW'(i));
    idle(4);

    // Backpressure
    f_rsp_ready = 1'b0;
    f_send(9'h010);
    f_send(9'h011);
    f_req_addr = 9'h012;
    repeat (3) step();
    f_rsp_ready = 1'b1;
    f_send(9'h012);
    idle(4);

    // Loader starvation under continuous fetch
    f_req_valid = 1'b1;
    f_req_addr  = 9'h030;
    l_req_we    = 1'b0;
    l_req_addr  = 9'h1FF;
    l_req_valid = 1'b1;
    for (int n = 0; n < 20 && l_req_valid; n++) begin
      step();
      if (f_hs) f_req_addr = f_req_addr + 9'd1;
      if (l_hs) l_req_valid = 1'b0;
    end
    if (l_req_valid) begin
      $display("FAIL starve_timeout loader never granted");
      $fatal(1, "loader starved");
    end
    idle(4);

    // Write then read of the same address
    l_send(1'b1, 9'h005, 32'hDEADBEEF);
    f_send(9'h005);
    idle(4);

    // Flush with one older entry buffered
    f_rsp_ready = 1'b0;
    f_send(9'h01F);
    f_send(9'h020);
    f_req_valid = 1'b0;
    f_flush = 1'b1;
    step();
    f_flush = 1'b0;
    f_rsp_ready = 1'b1;
    f_send(9'h040);
    idle(4);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!f_req_valid || f_hs) begin
        f_req_valid = ($urandom % 4) != 0;
        f_req_addr  = AW'($urandom % 32);
      end
      if (!l_req_valid || l_hs) begin
        l_req_valid = ($urandom % 3) == 0;
        l_req_we    = 1'($urandom % 2);
        l_req_addr  = AW'($urandom % 32);
        l_req_wdata = $urandom;
      end
      f_rsp_ready = ($urandom % 4) != 0;
      l_rsp_ready = 1'($urandom % 2);
      f_flush     = ($urandom % 20) == 0;
      step();
    end
    f_flush = 1'b0;
    idle(1);
    for (int n = 0; n < 50 && busy; n++) step();
    tb_final = 1'b1;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
